// File: rtl/mjpeg_pkg.sv
// Shared MJPEG constants: block geometry, coefficient width and component tag encodings.
package mjpeg_pkg;

  localparam int unsigned BLK_SIZE = 64;
  localparam int unsigned COEF_W   = 12;

  localparam logic [1:0] COMP_Y  = 2'd1;
  localparam logic [1:0] COMP_CB = 2'd2;
  localparam logic [1:0] COMP_CR = 2'd3;

  // 4:2:0 MCU ordering: four luma blocks, then Cb, then Cr.
  function automatic logic [1:0] comp_of_blk(input int unsigned blk);
    if (blk < 4) begin
      return COMP_Y;
    end else if (blk == 4) begin
      return COMP_CB;
    end else begin
      return COMP_CR;
    end
  endfunction

endpackage

// File: rtl/zigzag_lut.sv
// Combinational JPEG zigzag-to-raster index map for one 8x8 block.
module zigzag_lut
  import mjpeg_pkg::*;
(
  input  logic [5:0] zz_idx_i,
  output logic [5:0] raster_idx_o
);

  localparam logic [5:0] ZzToRaster [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  assign raster_idx_o = ZzToRaster[zz_idx_i];

endmodule

// File: rtl/inverse_zigzag_buffer.sv
// Ping-pong 8x8 block buffer: accepts coefficients in zigzag order and emits them in raster
// order with start/end-of-block markers and a per-block component tag.
module inverse_zigzag_buffer
  import mjpeg_pkg::*;
#(
  parameter int unsigned DW           = COEF_W,
  parameter int unsigned BLKS_PER_MCU = 6
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sob,
  output logic          out_eob,
  output logic [1:0]    out_comp
);

  localparam int unsigned   AW       = $clog2(BLK_SIZE);
  localparam int unsigned   BW       = (BLKS_PER_MCU > 1) ? $clog2(BLKS_PER_MCU) : 1;
  localparam logic [AW-1:0] AddrLast = AW'(BLK_SIZE - 1);
  localparam logic [BW-1:0] BlkLast  = BW'(BLKS_PER_MCU - 1);

  logic [DW-1:0] bank0_mem [BLK_SIZE];
  logic [DW-1:0] bank1_mem [BLK_SIZE];

  logic [AW-1:0] wr_idx_q, wr_addr, rd_addr_q;
  logic          wr_sel_q, rd_sel_q, iss_sel_q;
  logic [1:0]    full_q, full_d;
  logic [BW-1:0] blk_q;
  logic [DW-1:0] rd_data_q, out_data_q;
  logic          s1_valid_q, s1_sob_q, s1_eob_q;
  logic          out_valid_q, out_sob_q, out_eob_q;
  logic          wr_fire, out_fire, eob_fire, out_load, rd_en;

  zigzag_lut u_zigzag_lut (
    .zz_idx_i     (wr_idx_q),
    .raster_idx_o (wr_addr)
  );

  assign in_ready = ~full_q[wr_sel_q];
  assign wr_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;
  assign eob_fire = out_fire & out_eob_q;
  assign out_load = s1_valid_q & (~out_valid_q | out_ready);
  // iss_sel runs ahead of rd_sel so the next bank is fetched while the previous one drains.
  assign rd_en    = full_q[iss_sel_q] & (~s1_valid_q | out_load);

  always_comb begin
    full_d = full_q;
    if (wr_fire && (wr_idx_q == AddrLast)) full_d[wr_sel_q] = 1'b1;
    if (eob_fire) full_d[rd_sel_q] = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (wr_fire && !wr_sel_q) bank0_mem[wr_addr] <= in_data;
    if (wr_fire && wr_sel_q)  bank1_mem[wr_addr] <= in_data;
    if (rd_en) rd_data_q <= iss_sel_q ? bank1_mem[rd_addr_q] : bank0_mem[rd_addr_q];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_idx_q    <= '0;
      wr_sel_q    <= 1'b0;
      full_q      <= 2'b00;
      iss_sel_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_sel_q    <= 1'b0;
      blk_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_sob_q    <= 1'b0;
      s1_eob_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      full_q <= full_d;
      if (wr_fire) begin
        wr_idx_q <= wr_idx_q + 1'b1;
        if (wr_idx_q == AddrLast) wr_sel_q <= ~wr_sel_q;
      end
      if (rd_en) begin
        rd_addr_q  <= rd_addr_q + 1'b1;
        s1_valid_q <= 1'b1;
        s1_sob_q   <= (rd_addr_q == '0);
        s1_eob_q   <= (rd_addr_q == AddrLast);
        if (rd_addr_q == AddrLast) iss_sel_q <= ~iss_sel_q;
      end else if (out_load) begin
        s1_valid_q <= 1'b0;
      end
      if (out_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rd_data_q;
        out_sob_q   <= s1_sob_q;
        out_eob_q   <= s1_eob_q;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_sob_q   <= 1'b0;
        out_eob_q   <= 1'b0;
      end
      if (eob_fire) begin
        rd_sel_q <= ~rd_sel_q;
        blk_q    <= (blk_q == BlkLast) ? '0 : blk_q + 1'b1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sob   = out_sob_q;
  assign out_eob   = out_eob_q;
  assign out_comp  = out_valid_q ? comp_of_blk(32'(blk_q)) : 2'd0;

endmodule

// File: tb/tb_inverse_zigzag_buffer.sv
// Randomized bench for inverse_zigzag_buffer against a diagonal-walk zigzag reference model.
module tb_inverse_zigzag_buffer;

  localparam int DW = 12;
  localparam int NB = 6;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sob, out_eob;
  logic [1:0]    out_comp;

  always #5 sys_clk = ~sys_clk;

  inverse_zigzag_buffer #(.DW(DW), .BLKS_PER_MCU(NB)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .out_comp  (out_comp)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sob;
    logic          eob;
    logic [1:0]    comp;
    int            cyc;
  } word_t;

  word_t         exp_q[$];
  word_t         obs_q[$];
  int            zz2r[64];
  int            r2zz[64];
  logic [DW-1:0] mdl_words[64];
  int            mdl_cnt = 0;
  int            mdl_blk = 0;
  int            cyc = 0;
  int            last_acc_cyc = 0;
  int            checks = 0;
  int            failures = 0;

  // Zigzag order: walk anti-diagonals, even ones bottom-left to top-right, odd ones the reverse.
  function automatic void build_zigzag();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int row = hi; row >= lo; row--) begin
          zz2r[k] = row * 8 + (s - row);
          k++;
        end
      end else begin
        for (int row = lo; row <= hi; row++) begin
          zz2r[k] = row * 8 + (s - row);
          k++;
        end
      end
    end
    for (int i = 0; i < 64; i++) r2zz[zz2r[i]] = i;
  endfunction

  function automatic logic [1:0] comp_of(input int b);
    if (b < 4) return 2'd1;
    if (b == 4) return 2'd2;
    return 2'd3;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d);
    word_t w;
    mdl_words[mdl_cnt] = d;
    mdl_cnt++;
    last_acc_cyc = cyc;
    if (mdl_cnt == 64) begin
      for (int r = 0; r < 64; r++) begin
        w.data = mdl_words[r2zz[r]];
        w.sob  = (r == 0);
        w.eob  = (r == 63);
        w.comp = comp_of(mdl_blk);
        w.cyc  = cyc;
        exp_q.push_back(w);
      end
      mdl_cnt = 0;
      mdl_blk = (mdl_blk + 1) % NB;
    end
  endtask

  task automatic tick(input logic iv, input logic [DW-1:0] d, input logic ordy, output logic acc);
    word_t w;
    @(negedge sys_clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (acc) model_accept(d);
    if (out_valid && out_ready) begin
      w.data = out_data;
      w.sob  = out_sob;
      w.eob  = out_eob;
      w.comp = out_comp;
      w.cyc  = cyc;
      obs_q.push_back(w);
    end
    cyc++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    obs_q.delete();
    mdl_cnt = 0;
    mdl_blk = 0;
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic drain(input int n, input int budget);
    logic acc;
    int   b = 0;
    while (obs_q.size() < n && b < budget) begin
      tick(1'b0, '0, 1'b1, acc);
      b++;
    end
  endtask

  function automatic int first_bad();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sob !== exp_q[i].sob ||
          obs_q[i].eob !== exp_q[i].eob || obs_q[i].comp !== exp_q[i].comp) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      failures++; $display("FAIL reset_out_data got=%h want=0", out_data);
    end
    checks++;
    if (out_comp !== 2'd0) begin
      failures++; $display("FAIL reset_out_comp got=%0d want=0", out_comp);
    end
    checks++;
    if ({out_sob, out_eob} !== 2'b00) begin
      failures++; $display("FAIL reset_sob_eob got=%b want=00", {out_sob, out_eob});
    end
    model_clear();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_single_block();
    logic acc;
    int   k = 0;
    int   n = 0;
    int   bad;
    apply_reset();
    while (k < 64 && n < 200) begin
      tick(1'b1, DW'(k), 1'b1, acc);
      if (acc) k++;
      n++;
    end
    drain(64, 200);
    checks++;
    if (obs_q.size() != 64) begin
      failures++; $display("FAIL single_count got=%0d want=64", obs_q.size());
    end
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL single_data idx=%0d got=%h want=%h", bad, obs_q[bad].data, exp_q[bad].data);
    end
    if (obs_q.size() == 64) begin
      checks++;
      if (obs_q[0].cyc != last_acc_cyc + 3) begin
        failures++;
        $display("FAIL single_latency got=%0d want=%0d", obs_q[0].cyc - last_acc_cyc - 1, 2);
      end
      checks++;
      if (obs_q[1].data !== 12'd1 || obs_q[8].data !== 12'd2 || obs_q[16].data !== 12'd3 ||
          obs_q[9].data !== 12'd4) begin
        failures++;
        $display("FAIL single_points got=%0d,%0d,%0d,%0d want=1,2,3,4", obs_q[1].data,
                 obs_q[8].data, obs_q[16].data, obs_q[9].data);
      end
      checks++;
      if (obs_q[0].sob !== 1'b1 || obs_q[63].eob !== 1'b1 || obs_q[0].comp !== 2'd1) begin
        failures++;
        $display("FAIL single_flags got sob=%b eob=%b comp=%0d want 1 1 1", obs_q[0].sob,
                 obs_q[63].eob, obs_q[0].comp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d[384];
    logic [1:0]    comps[6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
    logic          acc;
    int            i = 0;
    int            n = 0;
    int            gaps = 0;
    int            bad;
    apply_reset();
    for (int j = 0; j < 384; j++) d[j] = DW'($urandom);
    while (i < 384 && n < 1000) begin
      tick(1'b1, d[i], 1'b1, acc);
      if (acc) i++;
      n++;
    end
    drain(384, 300);
    checks++;
    if (i != 384 || obs_q.size() != 384) begin
      failures++; $display("FAIL b2b_count in=%0d out=%0d want=384", i, obs_q.size());
    end
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL b2b_data idx=%0d got=%h want=%h", bad, obs_q[bad].data, exp_q[bad].data);
    end
    if (obs_q.size() == 384) begin
      for (int b = 0; b < 6; b++) begin
        checks++;
        if (obs_q[64 * b].comp !== comps[b]) begin
          failures++;
          $display("FAIL b2b_comp blk=%0d got=%0d want=%0d", b, obs_q[64 * b].comp, comps[b]);
        end
        for (int r = 1; r < 64; r++)
          if (obs_q[64 * b + r].cyc != obs_q[64 * b + r - 1].cyc + 1) gaps++;
      end
      checks++;
      if (gaps != 0) begin
        failures++; $display("FAIL b2b_gaps got=%0d want=0", gaps);
      end
      checks++;
      if (obs_q[383].cyc - obs_q[0].cyc > 398) begin
        failures++;
        $display("FAIL b2b_span got=%0d want<=398", obs_q[383].cyc - obs_q[0].cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d[192];
    logic [DW-1:0] held = '0;
    logic          acc;
    logic          seen = 1'b0;
    int            i = 0;
    int            n = 0;
    int            changes = 0;
    int            bad;
    apply_reset();
    for (int j = 0; j < 192; j++) d[j] = DW'($urandom);
    for (int c = 0; c < 200; c++) begin
      tick(i < 192, (i < 192) ? d[i] : '0, 1'b0, acc);
      if (acc) i++;
      if (out_valid) begin
        if (!seen) begin
          held = out_data;
          seen = 1'b1;
        end else if (out_data !== held) begin
          changes++;
        end
      end
    end
    checks++;
    if (i != 128) begin
      failures++; $display("FAIL bp_accepts got=%0d want=128", i);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready);
    end
    checks++;
    if (!seen || changes != 0) begin
      failures++; $display("FAIL bp_hold seen=%b changes=%0d want seen=1 changes=0", seen, changes);
    end
    checks++;
    if (exp_q.size() == 0 || held !== exp_q[0].data) begin
      failures++; $display("FAIL bp_head got=%h want=%h", held, d[0]);
    end
    while ((i < 192 || obs_q.size() < 192) && n < 1000) begin
      tick(i < 192, (i < 192) ? d[i] : '0, 1'b1, acc);
      if (acc) i++;
      n++;
    end
    checks++;
    if (obs_q.size() != 192) begin
      failures++; $display("FAIL bp_count got=%0d want=192", obs_q.size());
    end
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL bp_data idx=%0d got=%h want=%h", bad, obs_q[bad].data, exp_q[bad].data);
    end
  endtask

  task automatic test_random();
    localparam int NW = 20 * 64;
    logic [DW-1:0] d[NW];
    logic          acc;
    int            i = 0;
    int            n = 0;
    int            bad;
    apply_reset();
    for (int j = 0; j < NW; j++) begin
      case ($urandom_range(0, 9))
        0:       d[j] = 12'h800;
        1:       d[j] = 12'h7FF;
        default: d[j] = DW'($urandom);
      endcase
    end
    while ((i < NW || obs_q.size() < NW) && n < 20000) begin
      tick((i < NW) && ($urandom_range(0, 1) == 1), (i < NW) ? d[i] : '0,
           $urandom_range(0, 1) == 1, acc);
      if (acc) i++;
      n++;
    end
    checks++;
    if (i != NW || exp_q.size() != NW) begin
      failures++; $display("FAIL rand_accepts got=%0d want=%0d", i, NW);
    end
    checks++;
    if (obs_q.size() != NW) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), NW);
    end
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL rand_word idx=%0d got=%h/%b%b/%0d want=%h/%b%b/%0d", bad, obs_q[bad].data,
               obs_q[bad].sob, obs_q[bad].eob, obs_q[bad].comp, exp_q[bad].data,
               exp_q[bad].sob, exp_q[bad].eob, exp_q[bad].comp);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d[64];
    logic          acc;
    int            i = 0;
    int            n = 0;
    int            bad;
    apply_reset();
    while (i < 158 && n < 400) begin
      tick(1'b1, DW'($urandom), 1'b1, acc);
      if (acc) i++;
      n++;
    end
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_comp !== 2'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got valid=%b data=%h comp=%0d rdy=%b want 0 0 0 1", out_valid,
               out_data, out_comp, in_ready);
    end
    model_clear();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int j = 0; j < 64; j++) d[j] = DW'($urandom);
    i = 0;
    n = 0;
    while (i < 64 && n < 200) begin
      tick(1'b1, d[i], 1'b1, acc);
      if (acc) i++;
      n++;
    end
    drain(64, 200);
    checks++;
    if (obs_q.size() != 64) begin
      failures++; $display("FAIL mid_count got=%0d want=64", obs_q.size());
    end
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL mid_data idx=%0d got=%h want=%h", bad, obs_q[bad].data, exp_q[bad].data);
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[0].comp !== 2'd1) begin
      failures++; $display("FAIL mid_comp got=%0d want=1", (obs_q.size() > 0) ? obs_q[0].comp : 0);
    end
  endtask

  initial begin
    build_zigzag();
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inverse_zigzag_buffer.md
INVERSE_ZIGZAG_BUFFER -- requirements
Module: inverse_zigzag_buffer

Interface
REQ-001 Parameter DW, default 12: coefficient width, two's complement.
REQ-002 Parameter BLKS_PER_MCU, default 6: blocks per MCU for component tagging (4:2:0, Y,Y,Y,Y,Cb,Cr).
REQ-003 sys_clk  input  1  clock; all logic on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  DW  signed coefficient, zigzag scan order.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  buffer can accept in_data this cycle.
REQ-008 out_data  output  DW  signed coefficient, raster (row-major) order.
REQ-009 out_valid  output  1  out_data/out_sob/out_eob/out_comp valid.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_sob  output  1  first word of a block (raster index 0).
REQ-012 out_eob  output  1  last word of a block (raster index 63).
REQ-013 out_comp  output  2  component tag: 1=Y, 2=Cb, 3=Cr; 0 when out_valid=0.

Function
REQ-014 Transfer occurs on a cycle where valid and ready are both 1, independently on each side.
REQ-015 Two 64xDW banks (ping-pong); each bank has a full flag; wr_sel and rd_sel 1-bit pointers.
REQ-016 Write side: counter wr_idx 0..63 counts accepted input words; word k written to bank[wr_sel] at address zz2raster(k) (standard JPEG zigzag table; k=0->0, 1->1, 2->8, 3->16, 63->63).
REQ-017 On acceptance with wr_idx=63: wr_idx wraps to 0, bank[wr_sel].full set, wr_sel toggles.
REQ-018 in_ready = NOT bank[wr_sel].full; combinational from registered flags only (no path from in_valid).
REQ-019 Read side: when bank[rd_sel].full, read raster addresses 0..63 sequentially; synchronous memory, 1-cycle read latency, followed by output register.
REQ-020 Output register holds out_data and flags stable while out_valid=1 and out_ready=0; read address advances only when output register is empty or being consumed (no lost/duplicated words).
REQ-021 On acceptance of the out_eob word: bank[rd_sel].full cleared, rd_sel toggles, block counter advances.
REQ-022 Latency: with out_ready=1, first word (out_sob) of a block valid 2 cycles after acceptance of its 64th input word; then one word per cycle.
REQ-023 Throughput: sustained 1 word/cycle both sides; writer may fill one bank while reader drains the other.
REQ-024 Full set (REQ-017) and full clear (REQ-021) on the same bank/cycle cannot occur; set and clear on different banks in the same cycle both take effect.
REQ-025 Both banks full: in_ready=0 until reader frees a bank; in_ready rises the cycle after REQ-021 acceptance.
REQ-026 Block counter blk 0..BLKS_PER_MCU-1, wraps to 0; out_comp = 1 for blk<4, 2 for blk=4, 3 for blk=5.
REQ-027 Coefficient values pass bit-exact; no sign extension or saturation.

Reset
REQ-028 Asserting sys_rst_n low, at any time including mid-block, immediately clears: wr_idx, rd address, blk, wr_sel, rd_sel, both full flags, out_valid, out_sob, out_eob, out_comp to 0, out_data to 0.
REQ-029 After reset in_ready=1 on the first clock edge; partial blocks in flight are discarded; memory contents need no reset.

Structure
REQ-030 Shared package mjpeg_pkg holds BLK_SIZE=64, COEF_W=12, COMP_Y/COMP_CB/COMP_CR encodings.
REQ-031 Zigzag mapping in sub-module zigzag_lut (combinational, 6-bit zigzag index in, 6-bit raster index out), shared with the encoder-side block.
REQ-032 Banks inferred as simple dual-port RAM, one write and one read port each.

Verification
REQ-033 One block, in_data=k at zigzag index k, out_ready=1 -> raster output word r equals zigzag index of r (r=1->1, r=8->2, r=16->3, r=9->4); sob at r=0, eob at r=63; first word 2 cycles after 64th accept.
REQ-034 Six back-to-back blocks, both sides always ready -> 384 outputs, no gaps after first, in_ready never 0, out_comp 1,1,1,1,2,3.
REQ-035 out_ready=0 for 200 cycles while 3 blocks offered -> in_ready drops after 128 accepts; out_data held stable; on release all 192 words correct and in order.
REQ-036 Random in_valid/out_ready (50% each), 20 blocks of random signed values incl. -2048 and 2047 -> scoreboard match, no loss/duplication.
REQ-037 Reset pulse after 30 words of block 2 -> outputs cleared, in_ready=1; next full block emitted correctly with out_comp=1.
